// File: rtl/cmd_mreq_parser_pkg.sv
// Shared definitions for the command-stream MREQ parser.
// Holds the MREQ descriptor layout (pack/unpack helpers), write-format codes
// with their bytes-per-word mapping, the 6-byte host header layout and
// flag bit positions, and the parser FSM state type.
package cmd_mreq_parser_pkg;

  // Write-format codes carried in header b0[2:0]
  localparam logic [2:0] MREQ_WFMT_32S0 = 3'd0;
  localparam logic [2:0] MREQ_WFMT_16S0 = 3'd1;
  localparam logic [2:0] MREQ_WFMT_16S1 = 3'd2;
  localparam logic [2:0] MREQ_WFMT_8S0  = 3'd3;
  localparam logic [2:0] MREQ_WFMT_8S1  = 3'd4;
  localparam logic [2:0] MREQ_WFMT_8S2  = 3'd5;
  localparam logic [2:0] MREQ_WFMT_8S3  = 3'd6;

  // MREQ descriptor as presented to cmd_wb
  typedef struct packed {
    logic        wr;
    logic        aincr;
    logic [2:0]  wfmt;
    logic [7:0]  tag;
    logic [7:0]  wcnt;
    logic [23:0] addr;
  } mreq_t;

  localparam int unsigned MREQ_NBIT = $bits(mreq_t);

  // Host header: byte offsets and flag-byte bit positions
  localparam int unsigned CMD_HDR_LEN   = 6;
  localparam int unsigned CMD_HDR_FLAGS = 0;
  localparam int unsigned CMD_HDR_TAG   = 1;
  localparam int unsigned CMD_HDR_WCNT  = 2;
  localparam int unsigned CMD_HDR_ADDR0 = 3;
  localparam int unsigned CMD_HDR_ADDR1 = 4;
  localparam int unsigned CMD_HDR_ADDR2 = 5;

  localparam int unsigned HDR_FLAG_WR    = 7;
  localparam int unsigned HDR_FLAG_AINCR = 6;
  localparam int unsigned HDR_RSVD_HI    = 5;
  localparam int unsigned HDR_RSVD_LO    = 3;
  localparam int unsigned HDR_WFMT_HI    = 2;

  localparam int unsigned HDR_IDX_W = 3;
  localparam int unsigned PL_LEN_W  = 11;

  typedef enum logic {
    ST_HDR = 1'b0,
    ST_REQ = 1'b1
  } state_t;

  function automatic logic [MREQ_NBIT-1:0] pack_mreq(input mreq_t m);
    return m;
  endfunction

  function automatic mreq_t unpack_mreq(input logic [MREQ_NBIT-1:0] v);
    return mreq_t'(v);
  endfunction

  // Bytes per payload word; the unassigned code is treated as 32-bit
  function automatic logic [2:0] mreq_wfmt_bpw(input logic [2:0] wfmt);
    case (wfmt)
      MREQ_WFMT_32S0:                 return 3'd4;
      MREQ_WFMT_16S0, MREQ_WFMT_16S1: return 3'd2;
      MREQ_WFMT_8S0, MREQ_WFMT_8S1,
      MREQ_WFMT_8S2, MREQ_WFMT_8S3:   return 3'd1;
      default:                        return 3'd4;
    endcase
  endfunction

  // Payload byte count: (wcnt+1)*bpw for writes, 0 for reads (max 1024)
  function automatic logic [PL_LEN_W-1:0] mreq_pl_len(input logic       wr,
                                                      input logic [2:0] wfmt,
                                                      input logic [7:0] wcnt);
    logic [PL_LEN_W-1:0] words;
    words = PL_LEN_W'(wcnt) + PL_LEN_W'(1);
    if (!wr) return '0;
    case (mreq_wfmt_bpw(wfmt))
      3'd4:    return words << 2;
      3'd2:    return words << 1;
      default: return words;
    endcase
  endfunction

endpackage

// File: rtl/cmd_mreq_parser_if.sv
// Handshake bundle between the host stream, the parser and cmd_wb.
// Signal names follow the parser's point of view (i_ into it, o_ out of it).
//   host stream : i_host_data, i_host_valid, o_host_ready
//   mreq port   : o_mreq_valid, i_mreq_ready, o_mreq
//   payload     : o_pl_data, o_pl_valid, i_pl_ready
//   status      : o_err_hdr, o_err_timeout
// master = parser side, slave = host / cmd_wb side.
interface cmd_mreq_parser_if;
  import cmd_mreq_parser_pkg::*;

  logic [7:0]           i_host_data;
  logic                 i_host_valid;
  logic                 o_host_ready;
  logic                 o_mreq_valid;
  logic                 i_mreq_ready;
  logic [MREQ_NBIT-1:0] o_mreq;
  logic [7:0]           o_pl_data;
  logic                 o_pl_valid;
  logic                 i_pl_ready;
  logic                 o_err_hdr;
  logic                 o_err_timeout;

  modport master (
    input  i_host_data, i_host_valid, i_mreq_ready, i_pl_ready,
    output o_host_ready, o_mreq_valid, o_mreq, o_pl_data, o_pl_valid,
           o_err_hdr, o_err_timeout
  );

  modport slave (
    output i_host_data, i_host_valid, i_mreq_ready, i_pl_ready,
    input  o_host_ready, o_mreq_valid, o_mreq, o_pl_data, o_pl_valid,
           o_err_hdr, o_err_timeout
  );

endinterface

// File: rtl/cmd_mreq_parser.sv
// Parses the host command byte stream into MREQ descriptors for cmd_wb and,
// for writes, passes exactly the payload byte count through to cmd_wb's rx
// port with zero latency. Resynchronises on bad flag bytes and on headers
// that stall longer than TIMEOUT_CYCLES.
// Ports:
//   i_clk  : clock, all logic on the rising edge
//   i_rst  : synchronous active-high reset
//   bus    : cmd_mreq_parser_if.master (host stream, mreq, payload, errors)
module cmd_mreq_parser
  import cmd_mreq_parser_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cmd_mreq_parser_if.master    bus
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state,       w_state_n;
  logic [HDR_IDX_W-1:0]  r_idx,         w_idx_n;
  logic [4:0]            r_flags,       w_flags_n;
  logic [7:0]            r_tag,         w_tag_n;
  logic [7:0]            r_wcnt,        w_wcnt_n;
  logic [7:0]            r_addr0,       w_addr0_n;
  logic [7:0]            r_addr1,       w_addr1_n;
  logic [PL_LEN_W-1:0]   r_rem,         w_rem_n;
  logic [TCNT_W-1:0]     r_tcnt,        w_tcnt_n;
  mreq_t                 r_mreq,        w_mreq_n;
  logic                  r_mreq_valid,  w_mreq_valid_n;
  logic                  r_err_hdr,     w_err_hdr_n;
  logic                  r_err_timeout, w_err_timeout_n;

  logic w_host_ready;
  logic w_pl_valid;
  logic w_hs;
  logic w_rem_nz;

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_HDR;
      r_idx         <= '0;
      r_flags       <= '0;
      r_tag         <= '0;
      r_wcnt        <= '0;
      r_addr0       <= '0;
      r_addr1       <= '0;
      r_rem         <= '0;
      r_tcnt        <= '0;
      r_mreq        <= '0;
      r_mreq_valid  <= 1'b0;
      r_err_hdr     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_idx         <= w_idx_n;
      r_flags       <= w_flags_n;
      r_tag         <= w_tag_n;
      r_wcnt        <= w_wcnt_n;
      r_addr0       <= w_addr0_n;
      r_addr1       <= w_addr1_n;
      r_rem         <= w_rem_n;
      r_tcnt        <= w_tcnt_n;
      r_mreq        <= w_mreq_n;
      r_mreq_valid  <= w_mreq_valid_n;
      r_err_hdr     <= w_err_hdr_n;
      r_err_timeout <= w_err_timeout_n;
    end
  end

  // Next-state, header capture, payload pass-through and timeout
  always_comb begin
    w_state_n       = r_state;
    w_idx_n         = r_idx;
    w_flags_n       = r_flags;
    w_tag_n         = r_tag;
    w_wcnt_n        = r_wcnt;
    w_addr0_n       = r_addr0;
    w_addr1_n       = r_addr1;
    w_rem_n         = r_rem;
    w_tcnt_n        = r_tcnt;
    w_mreq_n        = r_mreq;
    w_mreq_valid_n  = r_mreq_valid;
    w_err_hdr_n     = 1'b0;
    w_err_timeout_n = 1'b0;
    w_host_ready    = 1'b0;
    w_pl_valid      = 1'b0;
    w_hs            = 1'b0;
    w_rem_nz        = (r_rem != '0);

    case (r_state)
      ST_HDR: begin
        w_host_ready = 1'b1;
        w_hs         = bus.i_host_valid;
        if (w_hs) begin
          w_tcnt_n = '0;
          // A flag byte with reserved bits set is dropped so the parser can
          // slide forward through stray payload bytes until it finds a header.
          if ((r_idx == '0) && (bus.i_host_data[HDR_RSVD_HI:HDR_RSVD_LO] != '0)) begin
            w_err_hdr_n = 1'b1;
          end else begin
            case (r_idx)
              HDR_IDX_W'(CMD_HDR_FLAGS): w_flags_n = {bus.i_host_data[HDR_FLAG_WR],
                                                      bus.i_host_data[HDR_FLAG_AINCR],
                                                      bus.i_host_data[HDR_WFMT_HI:0]};
              HDR_IDX_W'(CMD_HDR_TAG):   w_tag_n   = bus.i_host_data;
              HDR_IDX_W'(CMD_HDR_WCNT):  w_wcnt_n  = bus.i_host_data;
              HDR_IDX_W'(CMD_HDR_ADDR0): w_addr0_n = bus.i_host_data;
              HDR_IDX_W'(CMD_HDR_ADDR1): w_addr1_n = bus.i_host_data;
              default: begin
                // Last header byte: publish the descriptor and payload length
                w_mreq_n.wr    = r_flags[4];
                w_mreq_n.aincr = r_flags[3];
                w_mreq_n.wfmt  = r_flags[2:0];
                w_mreq_n.tag   = r_tag;
                w_mreq_n.wcnt  = r_wcnt;
                w_mreq_n.addr  = {bus.i_host_data, r_addr1, r_addr0};
                w_rem_n        = mreq_pl_len(r_flags[4], r_flags[2:0], r_wcnt);
                w_mreq_valid_n = 1'b1;
                w_state_n      = ST_REQ;
              end
            endcase
            if (r_idx == HDR_IDX_W'(CMD_HDR_ADDR2)) begin
              w_idx_n = '0;
            end else begin
              w_idx_n = r_idx + HDR_IDX_W'(1);
            end
          end
        end else if (r_idx != '0) begin
          // Idle inside a partial header: discard it after TIMEOUT_CYCLES
          if (r_tcnt == TCNT_LAST) begin
            w_idx_n         = '0;
            w_tcnt_n        = '0;
            w_err_timeout_n = 1'b1;
          end else begin
            w_tcnt_n = r_tcnt + TCNT_W'(1);
          end
        end
      end

      ST_REQ: begin
        w_tcnt_n     = '0;
        w_host_ready = bus.i_pl_ready && w_rem_nz;
        w_pl_valid   = bus.i_host_valid && w_rem_nz;
        w_hs         = bus.i_host_valid && w_host_ready;
        if (w_hs) begin
          w_rem_n = r_rem - PL_LEN_W'(1);
        end
        // Completion ends the request; unforwarded bytes stay in the stream
        if (bus.i_mreq_ready) begin
          w_state_n      = ST_HDR;
          w_idx_n        = '0;
          w_rem_n        = '0;
          w_mreq_valid_n = 1'b0;
        end
      end

      default: begin
        w_state_n = ST_HDR;
      end
    endcase
  end

  assign bus.o_host_ready  = w_host_ready;
  assign bus.o_pl_valid    = w_pl_valid;
  assign bus.o_pl_data     = bus.i_host_data;
  assign bus.o_mreq_valid  = r_mreq_valid;
  assign bus.o_mreq        = pack_mreq(r_mreq);
  assign bus.o_err_hdr     = r_err_hdr;
  assign bus.o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_cmd_mreq_parser.sv
// Scoreboard bench for cmd_mreq_parser: the stimulus side queues expected
// descriptors, payload lengths and payload bytes; a monitor samples one time
// unit before each rising edge and checks everything the DUT presents.
module tb_cmd_mreq_parser;
  import cmd_mreq_parser_pkg::*;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;

  cmd_mreq_parser_if bus();

  cmd_mreq_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  mreq_t      exp_mreq_q[$];
  int         exp_len_q[$];
  logic [7:0] exp_pl_q[$];
  int exp_err_hdr  = 0;
  int exp_err_to   = 0;
  int seen_err_hdr = 0;
  int seen_err_to  = 0;
  int pl_mode      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference payload length from the header rules
  function automatic int ref_len(input logic [7:0] flags, input logic [7:0] wcnt);
    int bpw;
    if (!flags[7]) return 0;
    case (flags[2:0])
      MREQ_WFMT_16S0, MREQ_WFMT_16S1: bpw = 2;
      MREQ_WFMT_8S0, MREQ_WFMT_8S1, MREQ_WFMT_8S2, MREQ_WFMT_8S3: bpw = 1;
      default: bpw = 4;
    endcase
    return (int'(wcnt) + 1) * bpw;
  endfunction

  function automatic logic [47:0] mk_hdr(input logic [7:0] flags, input logic [7:0] tag,
                                         input logic [7:0] wcnt, input logic [23:0] addr);
    return {addr, wcnt, tag, flags};
  endfunction

  function automatic mreq_t ref_mreq(input logic [47:0] h);
    mreq_t m;
    m.wr    = h[7];
    m.aincr = h[6];
    m.wfmt  = h[2:0];
    m.tag   = h[15:8];
    m.wcnt  = h[23:16];
    m.addr  = h[47:24];
    return m;
  endfunction

  // Present one byte from a falling edge until the DUT takes it
  task automatic drive_byte(input logic [7:0] b);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    bus.i_host_valid = 1'b1;
    bus.i_host_data  = b;
    while (!done) begin
      #4;
      if (bus.o_host_ready) done = 1'b1;
      @(negedge clk);
      n++;
      if (!done && n > 3000) begin
        n_vec++;
        n_miss++;
        $display("FAIL host_accept_timeout: byte 0x%0h not accepted in %0d cycles", b, n);
        done = 1'b1;
      end
    end
    bus.i_host_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.i_host_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Full request: header, payload, completion; optionally holds a 0xFF byte
  // on the host port before completion to show it is not taken early.
  task automatic do_req(input logic [47:0] h, input int gap_max, input bit seq_pl,
                        input bit probe_next);
    int         len;
    logic [7:0] pl_q[$];
    logic [7:0] b;
    len = ref_len(h[7:0], h[23:16]);
    exp_mreq_q.push_back(ref_mreq(h));
    exp_len_q.push_back(len);
    for (int i = 0; i < len; i++) begin
      b = seq_pl ? 8'(i) : 8'($urandom);
      pl_q.push_back(b);
      exp_pl_q.push_back(b);
    end
    for (int i = 0; i < 6; i++) begin
      drive_byte(h[8*i +: 8]);
      if (i < 5 && gap_max > 0) idle($urandom_range(0, gap_max));
    end
    foreach (pl_q[i]) begin
      drive_byte(pl_q[i]);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
    if (probe_next) begin
      bus.i_host_valid = 1'b1;
      bus.i_host_data  = 8'hFF;
      repeat (3) @(negedge clk);
    end else begin
      idle($urandom_range(0, 2));
    end
    bus.i_mreq_ready = 1'b1;
    @(negedge clk);
    bus.i_mreq_ready = 1'b0;
    if (probe_next) begin
      exp_err_hdr++;
      drive_byte(8'hFF);
    end
  endtask

  // Payload-ready pattern generator
  initial begin
    bus.i_pl_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (pl_mode)
        0:       bus.i_pl_ready = 1'b1;
        1:       bus.i_pl_ready = ~bus.i_pl_ready;
        default: bus.i_pl_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: one sample per cycle, just before the rising edge
  initial begin
    bit         m_in_req;
    int         m_rem;
    mreq_t      m_cur;
    bit         post_rst;
    bit         prev_to;
    logic [7:0] eb;
    m_in_req = 1'b0;
    m_rem    = 0;
    m_cur    = '0;
    post_rst = 1'b0;
    prev_to  = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        m_in_req = 1'b0;
        m_rem    = 0;
        exp_pl_q.delete();
        post_rst = 1'b1;
        prev_to  = 1'b0;
      end else begin
        if (post_rst) begin
          chk("rst_mreq_valid", 64'(bus.o_mreq_valid), 64'(0));
          chk("rst_mreq",       64'(bus.o_mreq),       64'(0));
          chk("rst_err_hdr",    64'(bus.o_err_hdr),    64'(0));
          chk("rst_err_to",     64'(bus.o_err_timeout), 64'(0));
          chk("rst_host_ready", 64'(bus.o_host_ready), 64'(1));
          post_rst = 1'b0;
        end
        if (bus.o_mreq_valid && !m_in_req) begin
          if (exp_mreq_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_mreq: got 0x%0h with nothing queued", bus.o_mreq);
          end else begin
            m_cur    = exp_mreq_q.pop_front();
            m_rem    = exp_len_q.pop_front();
            m_in_req = 1'b1;
          end
        end
        if (m_in_req) begin
          chk("mreq_valid", 64'(bus.o_mreq_valid), 64'(1));
          chk("mreq",       64'(bus.o_mreq),       64'(pack_mreq(m_cur)));
          chk("host_ready_req", 64'(bus.o_host_ready), 64'(bus.i_pl_ready && m_rem != 0));
          chk("pl_valid",       64'(bus.o_pl_valid),   64'(bus.i_host_valid && m_rem != 0));
          if (bus.i_host_valid && bus.i_pl_ready && m_rem != 0) begin
            if (exp_pl_q.size() == 0) begin
              n_vec++;
              n_miss++;
              $display("FAIL unexpected_payload: got 0x%0h with nothing queued", bus.o_pl_data);
            end else begin
              eb = exp_pl_q.pop_front();
              chk("pl_data", 64'(bus.o_pl_data), 64'(eb));
            end
            m_rem--;
          end
          if (bus.o_mreq_valid && bus.i_mreq_ready) m_in_req = 1'b0;
        end else begin
          chk("host_ready_hdr", 64'(bus.o_host_ready), 64'(1));
          chk("pl_valid_hdr",   64'(bus.o_pl_valid),   64'(0));
        end
        if (bus.o_err_hdr) seen_err_hdr++;
        if (bus.o_err_timeout) begin
          seen_err_to++;
          if (prev_to) begin
            n_vec++;
            n_miss++;
            $display("FAIL err_timeout_width: pulse longer than one cycle");
          end
        end
        prev_to = bus.o_err_timeout;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] h;
    logic [7:0]  fl;
    int          e0;
    int          t0;
    int          len;
    int          k;

    rst              = 1'b1;
    bus.i_host_valid = 1'b0;
    bus.i_host_data  = '0;
    bus.i_mreq_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write 32S0 wcnt 3, sequential payload, next byte held back until done
    do_req(mk_hdr(8'hC0, 8'hAA, 8'h03, 24'h000003), 0, 1'b1, 1'b1);

    // Read: no payload, next header accepted right after completion
    do_req(mk_hdr(8'h40 | {5'b0, MREQ_WFMT_8S0}, 8'hCC, 8'h03, 24'h000003), 0, 1'b0, 1'b0);

    // 16S0 wcnt 2 with toggling payload ready
    pl_mode = 1;
    do_req(mk_hdr(8'h80 | {5'b0, MREQ_WFMT_16S0}, 8'h11, 8'h02, 24'hABCDEF), 0, 1'b0, 1'b0);
    pl_mode = 0;

    // Bad flag byte then a good header
    e0 = seen_err_hdr;
    drive_byte(8'h38);
    exp_err_hdr++;
    do_req(mk_hdr(8'h80 | {5'b0, MREQ_WFMT_8S2}, 8'h42, 8'h04, 24'h00BEEF), 0, 1'b0, 1'b0);
    idle(2);
    chk("err_hdr_once", 64'(seen_err_hdr - e0), 64'(1));

    // Stalled partial header is discarded after exactly TO idle cycles
    t0 = seen_err_to;
    h  = mk_hdr(8'h80, 8'h99, 8'h07, 24'h111111);
    for (int i = 0; i < 3; i++) drive_byte(h[8*i +: 8]);
    idle(TO - 1);
    #6;
    chk("to_not_early", 64'(seen_err_to - t0), 64'(0));
    @(negedge clk);
    exp_err_to++;
    do_req(mk_hdr(8'hC0 | {5'b0, MREQ_WFMT_16S1}, 8'h5C, 8'h01, 24'h0A0B0C), 0, 1'b0, 1'b0);
    idle(2);
    chk("err_to_once", 64'(seen_err_to - t0), 64'(1));

    // Reset during payload forwarding, then a fresh header
    h   = mk_hdr(8'h80 | {5'b0, MREQ_WFMT_16S0}, 8'h5A, 8'h03, 24'h123456);
    len = ref_len(h[7:0], h[23:16]);
    exp_mreq_q.push_back(ref_mreq(h));
    exp_len_q.push_back(len);
    for (int i = 0; i < len; i++) exp_pl_q.push_back(8'(8'h60 + i));
    for (int i = 0; i < 6; i++) drive_byte(h[8*i +: 8]);
    for (int i = 0; i < 3; i++) drive_byte(8'(8'h60 + i));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_req(mk_hdr(8'h40, 8'h0E, 8'h00, 24'h000100), 0, 1'b0, 1'b0);

    // Largest payload: 256 words of 4 bytes
    do_req(mk_hdr(8'h80 | {5'b0, MREQ_WFMT_32S0}, 8'h77, 8'hFF, 24'hFFFFFF), 0, 1'b0, 1'b0);

    // Randomised traffic with stray bytes and stalled headers mixed in
    for (int r = 0; r < 40; r++) begin
      pl_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) begin
        fl = {2'($urandom_range(0, 3)), 3'($urandom_range(1, 7)), 3'($urandom_range(0, 7))};
        exp_err_hdr++;
        drive_byte(fl);
      end
      if ($urandom_range(0, 5) == 0) begin
        h = mk_hdr({2'($urandom_range(0, 3)), 3'b000, 3'($urandom_range(0, 7))},
                   8'($urandom), 8'($urandom), 24'($urandom));
        k = $urandom_range(1, 5);
        for (int i = 0; i < k; i++) drive_byte(h[8*i +: 8]);
        idle(TO);
        exp_err_to++;
      end
      fl = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'b000, 3'($urandom_range(0, 7))};
      do_req(mk_hdr(fl, 8'($urandom), 8'($urandom_range(0, 15)), 24'($urandom)),
             $urandom_range(0, 3), 1'b0, 1'b0);
    end
    pl_mode = 0;
    idle(5);

    chk("mreq_queue_drained", 64'(exp_mreq_q.size()), 64'(0));
    chk("pl_queue_drained",   64'(exp_pl_q.size()),   64'(0));
    chk("err_hdr_count",      64'(seen_err_hdr),      64'(exp_err_hdr));
    chk("err_to_count",       64'(seen_err_to),       64'(exp_err_to));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cmd_mreq_parser.md
# cmd_mreq_parser

Upstream front end of `cmd_wb`. Parses the host command byte stream into MREQ descriptors and drives `cmd_wb`'s mreq port. For write requests, it then forwards exactly the payload byte count to `cmd_wb`'s rx port. It also resynchronises the host stream on malformed or stalled headers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1000000: idle cycles inside a partial header before it is discarded (≥2).

Ports:
- `i_clk`  in  1  system clock; one clock, everything on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_host_data`  in  8  host byte.
- `i_host_valid`  in  1  host byte valid.
- `o_host_ready`  out  1  host byte accepted when valid&ready.
- `o_mreq_valid`  out  1  descriptor valid (to `cmd_wb` `i_mreq_valid`).
- `i_mreq_ready`  in  1  `cmd_wb` request complete (`o_mreq_ready`).
- `o_mreq`  out  MREQ_NBIT  packed descriptor (`pack_mreq` layout).
- `o_pl_data`  out  8  payload byte (to `cmd_wb` `i_rx_data`).
- `o_pl_valid`  out  1  payload valid.
- `i_pl_ready`  in  1  payload ready (`cmd_wb` `o_rx_ready`).
- `o_err_hdr`  out  1  one-cycle pulse: header byte 0 rejected.
- `o_err_timeout`  out  1  one-cycle pulse: partial header discarded.

## Operation
Header format: 6 bytes, in order:
- b0 is flags: bit7=wr, bit6=aincr, bits5:3 reserved (must be 0), bits2:0=wfmt.
- b1 is tag.
- b2 is wcnt.
- b3..b5 is addr[7:0], addr[15:8], addr[23:16] (little-endian).

Payload length for wr=1:
- Number of words is wcnt+1.
- Bytes per word: 4 for MREQ_WFMT_32S0, 2 for MREQ_WFMT_16Sx, 1 for MREQ_WFMT_8Sx.
- Payload length is (wcnt+1)·bpw bytes; max 1024, so the remaining-byte counter is 11 bits.
- For wr=0 the payload length is 0.

States:
- **HDR**: `o_host_ready`=1.
  - Each accepted byte is stored at index idx (0..5) and idx increments.
  - A b0 with nonzero reserved bits is dropped: `o_err_hdr` pulses and idx stays 0.
  - Accepting b5 loads `o_mreq` (registered) and the remaining-byte counter `rem`, then moves to REQ.
- **REQ**: `o_mreq_valid`=1 and `o_mreq` is held stable.
  - Payload pass-through is combinational: `o_pl_data`=`i_host_data`; `o_pl_valid`=`i_host_valid`&&rem≠0; `o_host_ready`=`i_pl_ready`&&rem≠0.
  - Each pass-through handshake decrements `rem`.
  - When `i_mreq_ready`=1, go to HDR with idx=0 and rem cleared.
  - If `i_mreq_ready` arrives with rem≠0, the unforwarded bytes stay in the host stream. They are not dropped; the next header parse resynchronises via the reserved-bit check.
- Timeout counter:
  - Runs only in HDR with idx≠0.
  - Clears on every accepted host byte.
  - On reaching TIMEOUT_CYCLES: idx←0, `o_err_timeout` pulses, counter clears.
  - Held at 0 in REQ.

## Timing
- Reset values:
  - `o_mreq_valid`=0, `o_mreq`=0, `o_err_*`=0.
  - State HDR, idx=0, rem=0, timeout counter=0.
  - `o_host_ready`=1 in the cycle after reset is sampled.
- Header throughput is one byte per cycle. `o_mreq_valid` rises on the edge that accepts b5, so it is visible in the following cycle.
- Payload path adds zero latency. `o_host_ready` depends combinationally on `i_pl_ready`.
- Handshake completing on edge N: `o_mreq_valid`=0 and `o_host_ready`=1 (HDR) in cycle N+1. The next header byte can be accepted in N+1.
- Reset mid-request: `o_mreq_valid` drops the cycle after `i_rst` is sampled high, and partial header and rem are discarded.
- Error pulses last exactly one cycle.

## Structure
- Header length, flag bit positions and the bpw function (`mreq_wfmt_bpw(wfmt)`) go in `mreq_defines.vh` beside `pack_mreq`/`unpack_mreq`.
- The header byte offsets (CMD_HDR_*) go in `cmd_defines.vh`.
- Single module, with no sub-modules.
- The bench reuses `stream_gen` only for payload-content checks.

## Test plan
- Header 0xC0,0xAA,0x03,0x03,0x00,0x00 (wr, aincr, 32S0, wcnt 3, addr 3) followed by bytes 0x00..0x0F, with `i_pl_ready`=1 → unpacked `o_mreq` is tag=AA, wr=1, aincr=1, wcnt=3, addr=0x000003; exactly 16 bytes forwarded; 17th host byte not accepted until `i_mreq_ready`.
- Read header with flags 0x40|MREQ_WFMT_8S0, tag 0xCC, wcnt 3, addr 3 → `o_mreq_valid` high, `o_pl_valid` never asserts; after `i_mreq_ready`, next header accepted the following cycle.
- Write with 16S0 and wcnt 2 with `i_pl_ready` toggling every other cycle → 6 payload bytes forwarded in order, and `o_host_ready` tracks `i_pl_ready`.
- b0=0x38 followed by a valid header → `o_err_hdr` pulses once, 0x38 dropped, valid header parsed correctly.
- TIMEOUT_CYCLES=16: send 3 header bytes, idle 16 cycles, then a full header → `o_err_timeout` pulses once and the new header decodes from b0.
- Assert `i_rst` for one cycle during payload forwarding → `o_mreq_valid`=0 the next cycle and a fresh header parses correctly.
